tog_event_decoder: RTL and testbench

//  Receive end of the team's toggle-signalling link. The transmit side is a T flip-flop that inverts a level once per event.

---
 rtl/tog_pkg.sv | 25 ++
 rtl/tog_sync.sv | 37 +++
 rtl/tog_event_decoder.sv | 107 ++++++++++
 tb/tb_tog_event_decoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tog_pkg.sv
// tog_pkg: shared types and defaults for the toggle event decoder.
// Honors macro TOG_SYNC_EN (sampler depth).
package tog_pkg;

  typedef enum logic {
    PRIME,
    RUN
  } tog_state_t;

  localparam int CNT_W_DEF   = 4;
  localparam int TOTAL_W_DEF = 16;

`ifdef TOG_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 1;
`endif

  function automatic int unsigned pend_max(
    input int unsigned w
  );
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/tog_sync.sv
// tog_sync: reset_n-cleared sampler for the toggle line, 1 or 2 stages.
// Ports: clk, reset_n, d (raw), q (sampled), q_nxt (value q loads next). Macro TOG_SYNC_EN.
module tog_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic q_nxt
);

`ifdef TOG_SYNC_EN
  logic s1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

  assign q_nxt = s1;
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else begin
      q <= d;
    end
  end

  assign q_nxt = d;
`endif

endmodule

// File: rtl/tog_event_decoder.sv
// tog_event_decoder: regenerates one event per t_in toggle, queues and drains them.
// Ports: clk, reset_n, t_in, evt_pulse, evt_valid/evt_ready, pending, total_cnt,
// overflow, clr_ovf. Macro TOG_SYNC_EN selects a 2-flop synchronizer on t_in.
module tog_event_decoder
  import tog_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TOTAL_W = TOTAL_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               t_in,
  output logic               evt_pulse,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [CNT_W-1:0]   pending,
  output logic [TOTAL_W-1:0] total_cnt,
  output logic               overflow,
  input  logic               clr_ovf
);

  localparam logic [CNT_W-1:0] PEND_MAX =
    CNT_W'(pend_max(CNT_W));
  localparam logic [1:0] PRIME_LAST =
    2'(SYNC_STAGES - 1);

  tog_state_t state;
  logic [1:0] prime_cnt;
  logic       s;
  logic       s_nxt;
  logic       prev;
  logic       tgl;
  logic       pop;
  logic       full;

  tog_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (t_in),
    .q       (s),
    .q_nxt   (s_nxt)
  );

  // PRIME tracks the value s is about to take, so prev equals s
  // once the sampler has filled; a high t_in at release is no event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PRIME;
      prime_cnt <= 2'd0;
      prev      <= 1'b0;
    end else begin
      unique case (state)
        PRIME: begin
          prev      <= s_nxt;
          prime_cnt <= prime_cnt + 2'd1;
          if (prime_cnt == PRIME_LAST) begin
            state <= RUN;
          end
        end
        RUN: begin
          prev <= s;
        end
        default: begin
          state <= PRIME;
        end
      endcase
    end
  end

  assign tgl       = (state == RUN) & (s ^ prev);
  assign evt_valid = (pending != '0);
  assign pop       = evt_valid & evt_ready;
  assign full      = (pending == PEND_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_pulse <= 1'b0;
      pending   <= '0;
      total_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      evt_pulse <= tgl;
      if (clr_ovf) begin
        overflow <= 1'b0;
      end
      // A drop below sets overflow after the clear, so set wins.
      unique case (1'b1)
        tgl & pop: begin
          total_cnt <= total_cnt + TOTAL_W'(1);
        end
        tgl & ~pop & ~full: begin
          pending   <= pending + CNT_W'(1);
          total_cnt <= total_cnt + TOTAL_W'(1);
        end
        tgl & ~pop & full: begin
          overflow <= 1'b1;
        end
        ~tgl & pop: begin
          pending <= pending - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tog_event_decoder.sv
// tb_tog_event_decoder: scoreboard bench for tog_event_decoder.
// Pulse timing via queue of expected cycles; counters via a reference model.
module tb_tog_event_decoder;

  localparam int CNT_W   = 4;
  localparam int TOTAL_W = 16;
`ifdef TOG_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               t_in = 1'b0;
  logic               evt_ready = 1'b0;
  logic               clr_ovf = 1'b0;
  logic               evt_pulse;
  logic               evt_valid;
  logic [CNT_W-1:0]   pending;
  logic [TOTAL_W-1:0] total_cnt;
  logic               overflow;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int pq[$];

  tog_event_decoder #(
    .CNT_W   (CNT_W),
    .TOTAL_W (TOTAL_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .t_in      (t_in),
    .evt_pulse (evt_pulse),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .pending   (pending),
    .total_cnt (total_cnt),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string   tag,
    input longint  got,
    input longint  exp
  );
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  logic [CNT_W-1:0]   m_pend;
  logic [TOTAL_W-1:0] m_tot;
  logic               m_ovf;
  logic               m_primed;
  logic               m_last;
  logic [1:0]         m_dly;
  logic               m_ev;
  logic               m_pop;
  logic               m_tog;

  assign m_ev  = m_dly[LAT-1];
  assign m_pop = (m_pend != '0) && evt_ready;
  assign m_tog = m_primed && (t_in != m_last);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend   <= '0;
      m_tot    <= '0;
      m_ovf    <= 1'b0;
      m_primed <= 1'b0;
      m_last   <= 1'b0;
      m_dly    <= 2'b00;
    end else begin
      m_primed <= 1'b1;
      m_last   <= t_in;
      m_dly    <= {m_dly[0], m_tog};
      if (clr_ovf) m_ovf <= 1'b0;
      if (m_ev && !m_pop) begin
        if (m_pend == 4'd15) begin
          m_ovf <= 1'b1;
        end else begin
          m_pend <= 4'(m_pend + 4'd1);
          m_tot  <= 16'(m_tot + 16'd1);
        end
      end else if (m_ev && m_pop) begin
        m_tot <= 16'(m_tot + 16'd1);
      end else if (m_pop) begin
        m_pend <= 4'(m_pend - 4'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (evt_pulse || (pq.size() != 0 && pq[0] <= cyc)) begin
        chk("pulse", evt_pulse,
            (pq.size() != 0 && pq[0] == cyc));
        if (pq.size() != 0 && pq[0] <= cyc) void'(pq.pop_front());
      end
      chk("m_pend", pending, m_pend);
      chk("m_valid", evt_valid, m_pend != '0);
      chk("m_total", total_cnt, m_tot);
      chk("m_ovf", overflow, m_ovf);
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic toggle();
    t_in = ~t_in;
    pq.push_back(cyc + 1 + LAT);
  endtask

  initial begin
    // reset with t_in high: no event at release
    t_in = 1'b1;
    reset_n = 1'b0;
    clks(2);
    reset_n = 1'b1;
    clks(10);
    chk("t1_pend", pending, 0);
    chk("t1_valid", evt_valid, 0);
    chk("t1_pulse", evt_pulse, 0);

    // three spaced toggles, consumer stalled
    for (int i = 0; i < 3; i++) begin
      toggle();
      clks(4);
    end
    chk("t2_pend", pending, 3);
    chk("t2_total", total_cnt, 3);

    // drain, extra ready ignored
    evt_ready = 1'b1;
    clks(1);
    chk("t3_pend2", pending, 2);
    clks(1);
    chk("t3_pend1", pending, 1);
    chk("t3_valid1", evt_valid, 1);
    clks(1);
    chk("t3_pend0", pending, 0);
    chk("t3_valid0", evt_valid, 0);
    clks(2);
    chk("t3_noundf", pending, 0);
    evt_ready = 1'b0;

    // fill past max; back-to-back toggles in part
    for (int i = 0; i < 16; i++) begin
      toggle();
      clks((i < 4) ? 1 : 2);
    end
    clks(LAT + 2);
    chk("t4_pend", pending, 15);
    chk("t4_total", total_cnt, 18);
    chk("t4_ovf", overflow, 1);
    clr_ovf = 1'b1;
    clks(1);
    clr_ovf = 1'b0;
    chk("t4_clr", overflow, 0);

    // toggle coincides with pop while full
    toggle();
    clks(LAT);
    evt_ready = 1'b1;
    clks(1);
    evt_ready = 1'b0;
    clks(2);
    chk("t5_pend", pending, 15);
    chk("t5_ovf", overflow, 0);
    chk("t5_total", total_cnt, 19);

    // drain to 5, then async reset mid-cycle
    evt_ready = 1'b1;
    clks(10);
    evt_ready = 1'b0;
    chk("t6_pend5", pending, 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rpend", pending, 0);
    chk("t6_rvalid", evt_valid, 0);
    chk("t6_rtotal", total_cnt, 0);
    chk("t6_rpulse", evt_pulse, 0);
    pq.delete();
    clks(2);
    reset_n = 1'b1;
    clks(10);
    chk("t6_pend", pending, 0);
    chk("t6_total", total_cnt, 0);
    toggle();
    clks(LAT + 2);
    chk("t6_after", pending, 1);
    chk("t6_atot", total_cnt, 1);

    chk("sb_empty", pq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
